// File: rtl/sprite_rom_writer.sv
`default_nettype none
// ============================================================================
//  Module      : sprite_rom_writer
//  Description : Encodes a 24-bit RGB pixel stream to palette indices with an
//                8-entry programmable palette and writes them in sequence into
//                the 4096 x 4 sprite memory.
//  Revision    : 1.0 - initial release
// ============================================================================
module sprite_rom_writer #(
  parameter int DEPTH      = 4096,
  parameter int ADDR_W     = 12,
  parameter int IDX_W      = 4,
  parameter int NUM_COLORS = 8
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              start,
  input  logic              abort,
  input  logic              in_valid,
  input  logic [23:0]       in_rgb,
  output logic              in_ready,
  input  logic              pal_we,
  input  logic [2:0]        pal_idx,
  input  logic [23:0]       pal_rgb,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [IDX_W-1:0]  wr_data,
  output logic              busy,
  output logic              done,
  output logic              miss_flag,
  output logic [12:0]       miss_count
);

  // Power-on palette, entry 0 in the least significant 24 bits.
  localparam logic [8*24-1:0] c_PAL_INIT = {
    24'hffc510, 24'he9580f, 24'hfd7b0f, 24'hffc113,
    24'h6b260e, 24'hffff15, 24'h9a3a06, 24'hffffff
  };

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  logic [23:0]       r_pal [NUM_COLORS];
  logic [ADDR_W-1:0] r_addr;
  logic              r_in_ready;
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [IDX_W-1:0]  r_wr_data;
  logic              r_busy;
  logic              r_done;
  logic              r_miss_flag;
  logic [12:0]       r_miss_count;

  logic              w_hit;
  logic [IDX_W-1:0]  w_idx;
  logic              w_accept;
  logic              w_last;

  // CAM match: scan from the top so the lowest matching entry is the one kept.
  always_comb begin
    w_hit = 1'b0;
    w_idx = '0;
    for (int i = NUM_COLORS - 1; i >= 0; i--) begin
      if (r_pal[i] == in_rgb) begin
        w_hit = 1'b1;
        w_idx = IDX_W'(i);
      end
    end
  end

  // An abort in the same cycle swallows the pixel on the bus.
  assign w_accept = in_valid && r_in_ready && !abort;
  assign w_last   = (r_addr == ADDR_W'(DEPTH - 1));

  // Palette storage; the encoder above sees the pre-write value this cycle.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < NUM_COLORS; i++) begin
        r_pal[i] <= c_PAL_INIT[i*24 +: 24];
      end
    end else if (pal_we) begin
      r_pal[pal_idx] <= pal_rgb;
    end
  end

  // Fill controller: state, address counter, write port and miss statistics.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state      <= S_IDLE;
      r_addr       <= '0;
      r_in_ready   <= 1'b0;
      r_wr_en      <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_miss_flag  <= 1'b0;
      r_miss_count <= '0;
    end else begin
      r_wr_en <= 1'b0;

      if (w_accept) begin
        r_wr_en   <= 1'b1;
        r_wr_addr <= r_addr;
        r_wr_data <= w_idx;
        r_addr    <= r_addr + 1'b1;
        if (!w_hit) begin
          r_miss_flag  <= 1'b1;
          r_miss_count <= r_miss_count + 1'b1;
        end
      end

      if (abort && (r_state != S_IDLE)) begin
        r_state    <= S_IDLE;
        r_in_ready <= 1'b0;
        r_busy     <= 1'b0;
        r_done     <= 1'b0;
      end else if (start && !abort && (r_state != S_FILL)) begin
        r_state      <= S_FILL;
        r_addr       <= '0;
        r_miss_flag  <= 1'b0;
        r_miss_count <= '0;
        r_in_ready   <= 1'b1;
        r_busy       <= 1'b1;
        r_done       <= 1'b0;
      end else if (w_accept && w_last) begin
        r_state    <= S_DONE;
        r_in_ready <= 1'b0;
        r_busy     <= 1'b0;
        r_done     <= 1'b1;
      end
    end
  end

  assign in_ready   = r_in_ready;
  assign wr_en      = r_wr_en;
  assign wr_addr    = r_wr_addr;
  assign wr_data    = r_wr_data;
  assign busy       = r_busy;
  assign done       = r_done;
  assign miss_flag  = r_miss_flag;
  assign miss_count = r_miss_count;

endmodule
`default_nettype wire

// File: tb/tb_sprite_rom_writer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sprite_rom_writer
//  Description : Scoreboard bench for sprite_rom_writer. Stimulus pushes the
//                hand-computed write (addr, data, cycle) for every accepted
//                pixel; a monitor pops and compares each wr_en cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sprite_rom_writer;

  logic        Clk;
  logic        Reset;
  logic        start;
  logic        abort;
  logic        in_valid;
  logic [23:0] in_rgb;
  logic        in_ready;
  logic        pal_we;
  logic [2:0]  pal_idx;
  logic [23:0] pal_rgb;
  logic        wr_en;
  logic [11:0] wr_addr;
  logic [3:0]  wr_data;
  logic        busy;
  logic        done;
  logic        miss_flag;
  logic [12:0] miss_count;

  sprite_rom_writer dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .start      (start),
    .abort      (abort),
    .in_valid   (in_valid),
    .in_rgb     (in_rgb),
    .in_ready   (in_ready),
    .pal_we     (pal_we),
    .pal_idx    (pal_idx),
    .pal_rgb    (pal_rgb),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy),
    .done       (done),
    .miss_flag  (miss_flag),
    .miss_count (miss_count)
  );

  typedef struct {
    logic [11:0] a;
    logic [3:0]  d;
    int          c;
  } wr_t;

  wr_t         sb[$];
  wr_t         mon_e;
  int          checks = 0;
  int          errors = 0;
  int          cyc    = 0;
  int          n_wr   = 0;
  bit          m_fill = 0;
  int          m_addr = 0;
  logic [23:0] pal0 [8];

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every write must match the oldest outstanding expectation.
  always @(negedge Clk) begin
    if (!Reset && wr_en) begin
      n_wr++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected no write", wr_addr, wr_data);
      end else begin
        mon_e = sb.pop_front();
        chk("wr_addr", 32'(wr_addr), 32'(mon_e.a));
        chk("wr_data", 32'(wr_data), 32'(mon_e.d));
        chk("wr_cycle", cyc, mon_e.c);
      end
    end
  end

  task automatic drive(input logic v, input logic [23:0] rgb, input logic [3:0] ed,
                       input logic pw = 1'b0, input logic [2:0] pi = 3'd0,
                       input logic [23:0] prgb = 24'd0);
    @(negedge Clk);
    in_valid = v;
    in_rgb   = rgb;
    pal_we   = pw;
    pal_idx  = pi;
    pal_rgb  = prgb;
    start    = 1'b0;
    abort    = 1'b0;
    chk("in_ready", 32'(in_ready), 32'(m_fill));
    if (v && m_fill) begin
      sb.push_back('{a: m_addr[11:0], d: ed, c: cyc + 1});
      m_addr++;
      if (m_addr == 4096) m_fill = 0;
    end
  endtask

  task automatic idle_inputs();
    start    = 1'b0;
    abort    = 1'b0;
    in_valid = 1'b0;
    in_rgb   = 24'd0;
    pal_we   = 1'b0;
    pal_idx  = 3'd0;
    pal_rgb  = 24'd0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_in_ready"},   32'(in_ready),   0);
    chk({tag, "_wr_en"},      32'(wr_en),      0);
    chk({tag, "_wr_addr"},    32'(wr_addr),    0);
    chk({tag, "_wr_data"},    32'(wr_data),    0);
    chk({tag, "_busy"},       32'(busy),       0);
    chk({tag, "_done"},       32'(done),       0);
    chk({tag, "_miss_flag"},  32'(miss_flag),  0);
    chk({tag, "_miss_count"}, 32'(miss_count), 0);
  endtask

  task automatic do_reset();
    @(negedge Clk);
    #1;
    Reset = 1'b1;
    idle_inputs();
    m_fill = 0;
    @(negedge Clk);
    check_zero("reset");
    chk("reset_pending", sb.size(), 0);
    sb.delete();
    Reset = 1'b0;
  endtask

  task automatic do_start();
    @(negedge Clk);
    idle_inputs();
    start = 1'b1;
    @(negedge Clk);
    start  = 1'b0;
    m_fill = 1;
    m_addr = 0;
    chk("start_busy", 32'(busy), 1);
  endtask

  task automatic drain();
    for (int k = 0; k < 10 && sb.size() != 0; k++) begin
      @(negedge Clk);
      #1;
    end
    chk("drain_pending", sb.size(), 0);
    sb.delete();
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    pal0[0] = 24'hffffff; pal0[1] = 24'h9a3a06; pal0[2] = 24'hffff15; pal0[3] = 24'h6b260e;
    pal0[4] = 24'hffc113; pal0[5] = 24'hfd7b0f; pal0[6] = 24'he9580f; pal0[7] = 24'hffc510;
    Reset = 1'b1;
    idle_inputs();
    do_reset();

    // Full back-to-back fill through the reset palette.
    n_wr = 0;
    do_start();
    for (int i = 0; i < 4096; i++) drive(1'b1, pal0[i % 8], 4'(i % 8));
    drain();
    chk("t1_done", 32'(done), 1);
    chk("t1_busy", 32'(busy), 0);
    chk("t1_in_ready", 32'(in_ready), 0);
    chk("t1_miss_count", 32'(miss_count), 0);
    chk("t1_miss_flag", 32'(miss_flag), 0);
    chk("t1_hold_addr", 32'(wr_addr), 32'hfff);
    chk("t1_hold_data", 32'(wr_data), 7);
    chk("t1_writes", n_wr, 4096);

    // Restart from DONE with two unmatched pixels.
    do_start();
    chk("t2_miss_cleared", 32'(miss_count), 0);
    chk("t2_done_cleared", 32'(done), 0);
    for (int i = 0; i < 4096; i++) begin
      if (i == 5 || i == 9) drive(1'b1, 24'h123456, 4'd0);
      else                  drive(1'b1, pal0[i % 8], 4'(i % 8));
    end
    drain();
    chk("t2_done", 32'(done), 1);
    chk("t2_miss_flag", 32'(miss_flag), 1);
    chk("t2_miss_count", 32'(miss_count), 2);

    // Palette write racing an accept, then duplicate entries.
    do_reset();
    do_start();
    drive(1'b1, 24'h00ff00, 4'd0, 1'b1, 3'd2, 24'h00ff00);
    drive(1'b1, 24'h00ff00, 4'd2);
    drive(1'b1, 24'hffff15, 4'd0);
    drive(1'b0, 24'h0, 4'd0, 1'b1, 3'd3, 24'habcdef);
    drive(1'b0, 24'h0, 4'd0, 1'b1, 3'd6, 24'habcdef);
    drive(1'b1, 24'habcdef, 4'd3);
    drive(1'b1, 24'h9a3a06, 4'd1);
    drive(1'b0, 24'h0, 4'd0);
    drain();
    chk("t3_miss_count", 32'(miss_count), 2);
    chk("t3_miss_flag", 32'(miss_flag), 1);
    chk("t3_last_addr", 32'(wr_addr), 4);
    chk("t3_busy", 32'(busy), 1);

    // Random valid gaps over a whole fill.
    do_reset();
    n_wr = 0;
    do_start();
    for (int k = 0; k < 20000 && m_fill; k++) begin
      drive(1'($urandom_range(0, 1)), pal0[m_addr % 8], 4'(m_addr % 8));
    end
    drain();
    chk("t5_writes", n_wr, 4096);
    chk("t5_done", 32'(done), 1);

    // Abort after 100 accepts, restart, then reset mid-fill.
    do_reset();
    do_start();
    for (int i = 0; i < 100; i++) begin
      if (i == 3) drive(1'b1, 24'h123456, 4'd0);
      else        drive(1'b1, pal0[i % 8], 4'(i % 8));
    end
    @(negedge Clk);
    abort    = 1'b1;
    in_valid = 1'b1;
    in_rgb   = pal0[1];
    chk("t6_ready_at_abort", 32'(in_ready), 1);
    m_fill = 0;
    for (int i = 0; i < 4; i++) drive(1'b1, pal0[2], 4'd2);
    drain();
    chk("t6_busy", 32'(busy), 0);
    chk("t6_done", 32'(done), 0);
    chk("t6_miss_before", 32'(miss_count), 1);
    do_start();
    chk("t6_restart_miss_count", 32'(miss_count), 0);
    chk("t6_restart_miss_flag", 32'(miss_flag), 0);
    for (int i = 0; i < 50; i++) drive(1'b1, pal0[(i + 3) % 8], 4'((i + 3) % 8));
    @(negedge Clk);
    #1;
    Reset    = 1'b1;
    in_valid = 1'b0;
    m_fill   = 0;
    @(negedge Clk);
    check_zero("t6_reset");
    chk("t6_reset_pending", sb.size(), 0);
    sb.delete();
    Reset = 1'b0;
    drive(1'b0, 24'h0, 4'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
